regfile_read_port: RTL and testbench
====================================

REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port reg_data, input, 32x64, packed contents of all 32 registers (index 31 = zero register).
REQ-004 SHALL have port wr_en, input, 1, register-file write strobe this cycle (bypass source).
REQ-005 SHALL have port wr_addr, input, 5, register index being written this cycle.
REQ-006 SHALL have port wr_data, input, 64, data being written this cycle.
REQ-007 SHALL have port req_valid, input, 1, read request present.
REQ-008 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready at posedge.
REQ-009 SHALL have port ra1 / ra2, input, 5 each, read addresses for ports A and B.
REQ-010 SHALL have port rsp_valid, output, 1, response at FIFO head valid.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes response when rsp_valid && rsp_ready at posedge.
REQ-012 SHALL have port rd1 / rd2, output, 64 each, head-of-FIFO read data for ports A and B.
REQ-013 SHALL have port rd_count, output, 16, number of accepted requests, wraps 0xFFFF -> 0x0000.

Function
REQ-014 SHALL resolve each address combinationally: addr 31 -> 64'h0; else if wr_en && wr_addr == addr -> wr_data (bypass); else reg_data[addr].
REQ-015 SHALL never bypass to address 31, even when wr_en && wr_addr == 31.
REQ-016 SHALL push the resolved {rd1, rd2} pair into a 2-entry response FIFO on an accepted request; data is a snapshot at the accepting edge.
REQ-017 SHALL NOT update FIFO entries already stored when their source registers are later written.
REQ-018 SHALL drive req_ready = (count < 2); no push when full; req_ready independent of req_valid.
REQ-019 SHALL drive rsp_valid = (count != 0); rd1/rd2 = head entry when rsp_valid, 64'h0 when empty.
REQ-020 SHALL have latency 1: request accepted at edge N appears on rsp_valid/rd1/rd2 after edge N when the FIFO was empty.
REQ-021 SHALL handle simultaneous push and pop: count unchanged, both pointers advance; at count 2 no push occurs (req_ready low), pop alone gives count 1.
REQ-022 SHALL wrap 1-bit read/write pointers modulo 2.
REQ-023 SHALL increment rd_count by 1 per accepted request, modulo 2^16.
REQ-024 SHALL preserve strict FIFO order of responses.

Reset
REQ-025 SHALL on reset assertion immediately clear count, pointers, FIFO storage and rd_count to 0, giving rsp_valid = 0, rd1 = rd2 = 0, req_ready = 1.
REQ-026 SHALL discard in-flight responses on reset mid-operation; no request is accepted while reset is high.
REQ-027 SHALL resume normal acceptance at the first posedge after reset deasserts.

Structure
REQ-028 SHALL take NUM_REGS = 32, DATA_W = 64, ADDR_W = 5, ZERO_REG = 31 and a rd_pair_t struct {rd1, rd2} from shared package regfile_pkg.
REQ-029 SHALL instantiate one sub-module, rsp_fifo2: 2-deep rd_pair_t FIFO with push, pop, full, empty and head.
REQ-030 SHALL keep address resolution and bypass in regfile_read_port, outside rsp_fifo2.

Verification
REQ-031 Bench SHALL cover plain read.
- Stimulus: reg_data[3] = 64'hA5A5, reg_data[7] = 64'h1234, ra1 = 3, ra2 = 7, one request, rsp_ready = 1.
- Required response: next cycle rsp_valid = 1, rd1 = 64'hA5A5, rd2 = 64'h1234, rd_count = 1.
REQ-032 Bench SHALL cover bypass.
- Stimulus: reg_data[5] = 0, wr_en = 1, wr_addr = 5, wr_data = 64'hFFFF_FFFF_FFFF_FFFF, ra1 = 5, request in same cycle.
- Required response: rd1 = all ones.
- Repeat with wr_addr = 31, ra1 = 31 -> rd1 = 0.
REQ-033 Bench SHALL cover backpressure.
- Stimulus: rsp_ready = 0, three back-to-back requests ra1 = 1, 2, 3.
- Required response: first two accepted, req_ready = 0 on the third.
- Then rsp_ready = 1: responses return in order for ra1 = 1, 2, and the third is accepted after the first pop.
REQ-034 Bench SHALL cover snapshot.
- Stimulus: accept read of reg 4 = 64'h10 with rsp_ready = 0, then change reg_data[4] to 64'h20.
- Required response: popped rd1 = 64'h10.
REQ-035 Bench SHALL cover simultaneous push/pop.
- Stimulus: count = 1, req_valid = 1 and rsp_ready = 1 held 4 cycles.
- Required response: count stays 1, one response per cycle, rd_count += 4.
REQ-036 Bench SHALL cover reset mid-operation.
- Stimulus: FIFO full, rd_count = 0x0005, assert reset between edges.
- Required response: rsp_valid = 0, rd1 = 0, req_ready = 1, rd_count = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file read port and its response FIFO.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 16;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
    } rd_pair_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry FIFO of read-data pairs; head reads as zero while empty.
module rsp_fifo2
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  rd_pair_t din,
    output logic     full,
    output logic     empty,
    output rd_pair_t head
);

    rd_pair_t   mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Dual-address register-file read port with write bypass, zero register and a
// two-deep response queue that snapshots read data at the accepting edge.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_data,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_W-1:0]                ra1,
    input  logic [ADDR_W-1:0]                ra2,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_W-1:0]                rd1,
    output logic [DATA_W-1:0]                rd2,
    output logic [CNT_W-1:0]                 rd_count
);

    // Handshakes: a transfer happens on a posedge where valid && ready are both
    // high; ready never depends on valid, and valid holds until the transfer.

    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0]               addr,
        input logic [NUM_REGS-1:0][DATA_W-1:0] regs,
        input logic                            we,
        input logic [ADDR_W-1:0]               wa,
        input logic [DATA_W-1:0]               wd
    );
        if (addr == ZERO_REG)
            return '0;
        else if (we && (wa == addr))
            return wd;
        else
            return regs[addr];
    endfunction

    rd_pair_t pair_in;
    rd_pair_t head;
    logic     full;
    logic     empty;
    logic     accept;
    logic     take;

    always_comb begin
        pair_in     = '0;
        pair_in.rd1 = resolve(ra1, reg_data, wr_en, wr_addr, wr_data);
        pair_in.rd2 = resolve(ra2, reg_data, wr_en, wr_addr, wr_data);
    end

    assign req_ready = !full;
    assign rsp_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign take      = rsp_valid && rsp_ready;
    assign rd1       = head.rd1;
    assign rd2       = head.rd2;

    rsp_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (take),
        .din   (pair_in),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_count <= '0;
        else if (accept)
            rd_count <= rd_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port against a queue-based reference model.
module tb_regfile_read_port;

  logic                clk;
  logic                reset;
  logic [31:0][63:0]   reg_data;
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [63:0]         wr_data;
  logic                req_valid;
  logic                req_ready;
  logic [4:0]          ra1;
  logic [4:0]          ra2;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rd1;
  logic [63:0]         rd2;
  logic [15:0]         rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {rd1, rd2} snapshots and an accepted-request counter.
  logic [127:0] exp_q[$];
  logic [15:0]  m_count;

  regfile_read_port dut (
    .clk       (clk),
    .reset     (reset),
    .reg_data  (reg_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ra1       (ra1),
    .ra2       (ra2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rd1       (rd1),
    .rd2       (rd2),
    .rd_count  (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd31) return 64'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return reg_data[a];
  endfunction

  function automatic logic [63:0] exp_rd1();
    return (exp_q.size() != 0) ? exp_q[0][127:64] : 64'h0;
  endfunction

  function automatic logic [63:0] exp_rd2();
    return (exp_q.size() != 0) ? exp_q[0][63:0] : 64'h0;
  endfunction

  // Advance one clock, applying the handshake rules to the model; returns #1 after the edge.
  task automatic advance();
    bit           acc;
    bit           pop;
    logic [127:0] snap;
    acc  = req_valid && (exp_q.size() < 2);
    pop  = rsp_ready && (exp_q.size() != 0);
    snap = {ref_read(ra1), ref_read(ra2)};
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(snap);
      m_count = m_count + 16'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 64'h0;
    ra1       = 5'd0;
    ra2       = 5'd0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: rsp_valid=%0b expected 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) reg_data[i] = {$urandom, $urandom};
    exp_q.delete();
    m_count = 16'd0;
    #3;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd1 !== 64'h0 || rd2 !== 64'h0 || rd_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: rsp_valid=%0b req_ready=%0b rd1=%h rd2=%h rd_count=%h expected 0/1/0/0/0",
               rsp_valid, req_ready, rd1, rd2, rd_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_plain_read();
    reg_data[3] = 64'hA5A5;
    reg_data[7] = 64'h1234;
    ra1 = 5'd3;
    ra2 = 5'd7;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    advance();
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rd1 !== 64'hA5A5 || rd2 !== 64'h1234 || rd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL plain_read: rsp_valid=%0b rd1=%h rd2=%h rd_count=%0d expected 1/a5a5/1234/1",
               rsp_valid, rd1, rd2, rd_count);
    end
    drain();
  endtask

  task automatic test_bypass();
    reg_data[5] = 64'h0;
    reg_data[0] = 64'h77;
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    ra1 = 5'd5;
    ra2 = 5'd0;
    req_valid = 1'b1;
    advance();
    req_valid = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (rd1 !== 64'hFFFF_FFFF_FFFF_FFFF || rd2 !== 64'h77) begin
      n_fail++;
      $display("FAIL bypass_hit: rd1=%h rd2=%h expected ffffffffffffffff/77", rd1, rd2);
    end
    drain();
    wr_en = 1'b1;
    wr_addr = 5'd31;
    ra1 = 5'd31;
    reg_data[31] = 64'hDEAD_BEEF;
    req_valid = 1'b1;
    advance();
    req_valid = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rd1 !== 64'h0) begin
      n_fail++;
      $display("FAIL bypass_zero_reg: rsp_valid=%0b rd1=%h expected 1/0", rsp_valid, rd1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    reg_data[1] = 64'h1111;
    reg_data[2] = 64'h2222;
    reg_data[3] = 64'h3333;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    ra1 = 5'd1;
    advance();
    ra1 = 5'd2;
    advance();
    ra1 = 5'd3;
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: req_ready=%0b rsp_valid=%0b expected 0/1", req_ready, rsp_valid);
    end
    advance();
    n_checks++;
    if (req_ready !== 1'b0 || rd1 !== 64'h1111 || rd_count !== m_count) begin
      n_fail++;
      $display("FAIL bp_hold: req_ready=%0b rd1=%h rd_count=%0d expected 0/1111/%0d",
               req_ready, rd1, rd_count, m_count);
    end
    rsp_ready = 1'b1;
    advance();
    n_checks++;
    if (rd1 !== 64'h2222 || req_ready !== 1'b1 || rd1 !== exp_rd1()) begin
      n_fail++;
      $display("FAIL bp_second: rd1=%h req_ready=%0b expected 2222/1", rd1, req_ready);
    end
    advance();
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rd1 !== 64'h3333 || rd_count !== m_count) begin
      n_fail++;
      $display("FAIL bp_third: rsp_valid=%0b rd1=%h rd_count=%0d expected 1/3333/%0d",
               rsp_valid, rd1, rd_count, m_count);
    end
    drain();
  endtask

  task automatic test_snapshot();
    reg_data[4] = 64'h10;
    ra1 = 5'd4;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    advance();
    req_valid = 1'b0;
    reg_data[4] = 64'h20;
    advance();
    advance();
    rsp_ready = 1'b1;
    n_checks++;
    if (rd1 !== 64'h10) begin
      n_fail++;
      $display("FAIL snapshot: rd1=%h expected 10", rd1);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] start_cnt;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    ra1 = 5'd10;
    advance();
    start_cnt = m_count;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra1 = 5'(11 + i);
      ra2 = 5'(20 + i);
      advance();
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rd1 !== exp_rd1() || rd2 !== exp_rd2()
          || rd1 !== reg_data[11 + i]) begin
        n_fail++;
        $display("FAIL simul_push_pop[%0d]: rsp_valid=%0b req_ready=%0b rd1=%h rd2=%h expected 1/1/%h/%h",
                 i, rsp_valid, req_ready, rd1, rd2, exp_rd1(), exp_rd2());
      end
    end
    n_checks++;
    if (rd_count !== start_cnt + 16'd4) begin
      n_fail++;
      $display("FAIL simul_count: rd_count=%0d expected %0d", rd_count, start_cnt + 16'd4);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i % 8 == 0) begin
        for (int r = 0; r < 32; r++) reg_data[r] = {$urandom, $urandom};
      end
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = {$urandom, $urandom};
      ra1       = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      ra2       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      advance();
      n_checks++;
      if (rsp_valid !== (exp_q.size() != 0) || req_ready !== (exp_q.size() < 2)
          || rd1 !== exp_rd1() || rd2 !== exp_rd2() || rd_count !== m_count) begin
        n_fail++;
        $display("FAIL random[%0d]: rsp_valid=%0b req_ready=%0b rd1=%h rd2=%h rd_count=%0d expected %0b/%0b/%h/%h/%0d",
                 i, rsp_valid, req_ready, rd1, rd2, rd_count,
                 exp_q.size() != 0, exp_q.size() < 2, exp_rd1(), exp_rd2(), m_count);
      end
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete();
    m_count = 16'd0;
    @(posedge clk);
    #1;
    reg_data[6] = 64'h66;
    ra1 = 5'd6;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) advance();
    rsp_ready = 1'b0;
    advance();
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rd_count !== 16'h0005 || rd_count !== m_count) begin
      n_fail++;
      $display("FAIL reset_mid_setup: req_ready=%0b rsp_valid=%0b rd_count=%h expected 0/1/0005",
               req_ready, rsp_valid, rd_count);
    end
    #2;
    reset = 1'b1;
    exp_q.delete();
    m_count = 16'd0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rd1 !== 64'h0 || rd2 !== 64'h0 || req_ready !== 1'b1 || rd_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: rsp_valid=%0b rd1=%h rd2=%h req_ready=%0b rd_count=%h expected 0/0/0/1/0",
               rsp_valid, rd1, rd2, req_ready, rd_count);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rd_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_held: rsp_valid=%0b rd_count=%h expected 0/0", rsp_valid, rd_count);
    end
    reset = 1'b0;
    advance();
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rd1 !== 64'h66 || rd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_resume: rsp_valid=%0b rd1=%h rd_count=%0d expected 1/66/1", rsp_valid, rd1, rd_count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_plain_read();
    test_bypass();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
